// File: rtl/fpaddsub.sv
// Parametrised multi-cycle floating-point adder/subtractor (sign|exp|mantissa, RNE, IEEE-style specials).
// Latency 5 + min(d,M+3) + n serial (5 with FPADDSUB_BARREL_EN defined); specials complete in 2.
// No backpressure: start is taken only while idle; the result and ready hold until the next accepted start.
module fpaddsub #(
    parameter int LOG_BIT = 3,
    parameter int EXP_BIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    addnot_sub,
    input  logic [2**LOG_BIT-1:0]   a,
    input  logic [2**LOG_BIT-1:0]   b,
    output logic [2**LOG_BIT-1:0]   out,
    output logic                    ready,
    output logic                    busy
);
    localparam int W  = 2**LOG_BIT;
    localparam int E  = EXP_BIT;
    localparam int M  = W - 1 - E;
    localparam int MW = M + 4;        // hidden bit, mantissa, guard, round, sticky
    localparam int XW = E + 2;        // signed working exponent with headroom both ways

    localparam logic [W-1:0]          QNAN     = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    localparam logic [E-1:0]          ALN_MAX  = E'(M + 3);
    localparam logic [E-1:0]          CNT_ONE  = 1;
    localparam logic signed [XW-1:0]  EXP_ONE  = 1;
    localparam logic signed [XW-1:0]  EXP_INF  = XW'(2**E - 1);

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          a_q, a_d, b_q, b_d, out_q, out_d, spec_res_q, spec_res_d;
    logic                  op_q, op_d, ready_q, ready_d, sign_q, sign_d, sub_q, sub_d, spec_q, spec_d;
    logic signed [XW-1:0]  exp_q, exp_d;
    logic [MW-1:0]         mx_q, mx_d, my_q, my_d;
    logic [E-1:0]          cnt_q, cnt_d;

    // Unpack view of the latched operands
    logic            sa, sb, sx, swap;
    logic [E-1:0]    ea, eb, ex, ey, d_u, aln_n;
    logic [M-1:0]    ma, mb, mx_u, my_u;
    logic            a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, is_spec;
    logic [W-1:0]    spec_val;

    // Datapath helpers
    logic [MW:0]           sum;
    logic [M:0]            mant;
    logic [M+1:0]          mant_r;
    logic                  rup;
    logic signed [XW-1:0]  exp_r;
    logic [M-1:0]          frac;
    logic [W-1:0]          rounded;

`ifdef FPADDSUB_BARREL_EN
    localparam int            LW     = $clog2(MW + 1);
    localparam logic [MW-1:0] ONE_MW = 1;
    logic [MW-1:0]  shifted, lost_mask;
    logic [LW-1:0]  lzc;
`endif

    // Operand decode, magnitude swap and special-case result
    always_comb begin
        sa       = a_q[W-1];
        sb       = b_q[W-1] ^ ~op_q;
        ea       = a_q[W-2:M];
        eb       = b_q[W-2:M];
        ma       = a_q[M-1:0];
        mb       = b_q[M-1:0];
        a_zero   = (ea == '0);
        b_zero   = (eb == '0);
        a_nan    = (&ea) && (|ma);
        b_nan    = (&eb) && (|mb);
        a_inf    = (&ea) && !(|ma);
        b_inf    = (&eb) && !(|mb);
        swap     = {eb, mb} > {ea, ma};
        sx       = swap ? sb : sa;
        ex       = swap ? eb : ea;
        ey       = swap ? ea : eb;
        mx_u     = swap ? mb : ma;
        my_u     = swap ? ma : mb;
        d_u      = ex - ey;
        aln_n    = (d_u > ALN_MAX) ? ALN_MAX : d_u;
        is_spec  = 1'b1;
        spec_val = '0;
        if (a_nan || b_nan) begin
            spec_val = QNAN;
        end else if (a_inf && b_inf) begin
            spec_val = (sa != sb) ? QNAN : {sa, {E{1'b1}}, {M{1'b0}}};
        end else if (a_inf) begin
            spec_val = {sa, {E{1'b1}}, {M{1'b0}}};
        end else if (b_inf) begin
            spec_val = {sb, {E{1'b1}}, {M{1'b0}}};
        end else if (a_zero && b_zero) begin
            spec_val = {sa & sb, {(W-1){1'b0}}};
        end else if (a_zero) begin
            spec_val = {sb, eb, mb};
        end else if (b_zero) begin
            spec_val = {sa, ea, ma};
        end else begin
            is_spec  = 1'b0;
        end
    end

    // Magnitude add/sub and round-to-nearest-even on the normalised magnitude
    always_comb begin
        sum    = sub_q ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});
        mant   = mx_q[MW-1:3];
        rup    = mx_q[2] & (mx_q[1] | mx_q[0] | mant[0]);
        mant_r = {1'b0, mant} + {{(M+1){1'b0}}, rup};
        exp_r  = mant_r[M+1] ? (exp_q + EXP_ONE) : exp_q;
        frac   = mant_r[M+1] ? mant_r[M:1] : mant_r[M-1:0];
        if (mx_q == '0) begin
            rounded = '0;
        end else if (exp_r >= EXP_INF) begin
            rounded = {sign_q, {E{1'b1}}, {M{1'b0}}};
        end else if (exp_r < EXP_ONE) begin
            rounded = {sign_q, {(W-1){1'b0}}};
        end else begin
            rounded = {sign_q, exp_r[E-1:0], frac};
        end
    end

`ifdef FPADDSUB_BARREL_EN
    // One-shot alignment with sticky collection, and leading-zero count for normalise
    always_comb begin
        shifted   = my_q >> cnt_q;
        lost_mask = (ONE_MW << cnt_q) - ONE_MW;
        lzc       = '0;
        for (int i = 0; i < MW; i++) begin
            if (mx_q[i]) lzc = LW'(MW - 1 - i);
        end
    end
`endif

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        out_d      = out_q;
        ready_d    = ready_q;
        sign_d     = sign_q;
        sub_d      = sub_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        exp_d      = exp_q;
        mx_d       = mx_q;
        my_d       = my_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = addnot_sub;
                    ready_d = 1'b0;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sign_d     = sx;
                sub_d      = sa ^ sb;
                exp_d      = {2'b00, ex};
                mx_d       = {1'b1, mx_u, 3'b000};
                my_d       = {1'b1, my_u, 3'b000};
                cnt_d      = aln_n;
                spec_d     = is_spec;
                spec_res_d = spec_val;
                // Specials skip the datapath; ROUND just presents the latched result
                state_d    = is_spec ? S_ROUND : S_ALIGN;
            end
            S_ALIGN: begin
`ifdef FPADDSUB_BARREL_EN
                my_d    = {shifted[MW-1:1], shifted[0] | (|(my_q & lost_mask))};
                state_d = S_ADD;
`else
                if (cnt_q == '0) begin
                    state_d = S_ADD;
                end else begin
                    my_d  = {1'b0, my_q[MW-1:2], my_q[1] | my_q[0]};
                    cnt_d = cnt_q - CNT_ONE;
                end
`endif
            end
            S_ADD: begin
                if (sum[MW]) begin
                    mx_d  = {sum[MW:2], sum[1] | sum[0]};
                    exp_d = exp_q + EXP_ONE;
                end else begin
                    mx_d  = sum[MW-1:0];
                end
                state_d = S_NORM;
            end
            S_NORM: begin
`ifdef FPADDSUB_BARREL_EN
                mx_d    = mx_q << lzc;
                exp_d   = exp_q - XW'(lzc);
                state_d = S_ROUND;
`else
                if (mx_q[MW-1] || (mx_q == '0)) begin
                    state_d = S_ROUND;
                end else begin
                    mx_d  = {mx_q[MW-2:0], 1'b0};
                    exp_d = exp_q - EXP_ONE;
                end
`endif
            end
            S_ROUND: begin
                out_d   = spec_q ? spec_res_q : rounded;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
            out_q      <= '0;
            ready_q    <= 1'b0;
            sign_q     <= 1'b0;
            sub_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            exp_q      <= '0;
            mx_q       <= '0;
            my_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            out_q      <= out_d;
            ready_q    <= ready_d;
            sign_q     <= sign_d;
            sub_q      <= sub_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            exp_q      <= exp_d;
            mx_q       <= mx_d;
            my_q       <= my_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out   = out_q;
    assign ready = ready_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpaddsub.sv
// Directed bench for fpaddsub at default parameters (W=8, E=4, M=3).
// Checks result words, start-to-ready latency and handshake behaviour in either build.
// Drives inputs at negedge / 1 time unit after posedge; samples 1 time unit after posedge.
module tb_fpaddsub;
    logic       clk = 1'b0;
    logic       rst_n, start, addnot_sub;
    logic [7:0] a, b, out;
    logic       ready, busy;
    int         checks = 0;
    int         failures = 0;

    fpaddsub dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addnot_sub(addnot_sub),
        .a(a), .b(b), .out(out), .ready(ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // Expected start-edge to ready latency; d is exponent difference, n left shifts
    function automatic int lat_of(input int d, input int n, input bit spec);
        if (spec) return 2;
`ifdef FPADDSUB_BARREL_EN
        return 5;
`else
        return 5 + ((d > 6) ? 6 : d) + n;
`endif
    endfunction

    // Waits for ready for at most 200 cycles, counting edges since acceptance
    task automatic wait_ready(input int lat0, output int lat);
        lat = lat0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (ready) break;
        end
    endtask

    task automatic run(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                       input logic iop, input logic [7:0] expv, input int exp_lat, input bit do_lat);
        int lat;
        @(negedge clk);
        a = ia; b = ib; addnot_sub = iop; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ia; b = ~ib; addnot_sub = ~iop;    // must not disturb the accepted operation
        chk({tag, "_accept"}, {30'd0, busy, ready}, 32'h2);
        wait_ready(0, lat);
        chk({tag, "_ready"}, {31'd0, ready}, 32'h1);
        chk({tag, "_out"}, {24'd0, out}, {24'd0, expv});
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'h0);
        if (do_lat) chk({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b0; start = 1'b0; addnot_sub = 1'b1; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {22'd0, out, ready, busy}, 32'h0);
        rst_n = 1'b1;

        run("add_3_2",      8'h44, 8'h40, 1'b1, 8'h4A, lat_of(0, 0, 0), 1'b1);
        // Result held while idle
        repeat (3) @(posedge clk);
        #1;
        chk("hold_ready", {23'd0, out, ready}, {23'd0, 8'h4A, 1'b1});

        run("sub_3_2",      8'h44, 8'h40, 1'b0, 8'h38, lat_of(0, 1, 0), 1'b1);
        run("tie_even",     8'h38, 8'h18, 1'b1, 8'h38, 0, 1'b0);
        run("tie_odd_up",   8'h39, 8'h18, 1'b1, 8'h3A, lat_of(4, 0, 0), 1'b1);
        run("round_carry",  8'h3F, 8'h18, 1'b1, 8'h40, lat_of(4, 0, 0), 1'b1);
        run("swap_small_a", 8'h18, 8'h38, 1'b1, 8'h38, lat_of(4, 0, 0), 1'b1);
        run("inf_m_inf",    8'h78, 8'h78, 1'b0, 8'h7C, lat_of(0, 0, 1), 1'b1);
        run("inf_m_ninf",   8'h78, 8'hF8, 1'b0, 8'h78, lat_of(0, 0, 1), 1'b1);
        run("ninf_p_3",     8'hF8, 8'h44, 1'b1, 8'hF8, lat_of(0, 0, 1), 1'b1);
        run("nan_p_3",      8'h79, 8'h44, 1'b1, 8'h7C, lat_of(0, 0, 1), 1'b1);
        run("max_overflow", 8'h77, 8'h77, 1'b1, 8'h78, lat_of(0, 0, 0), 1'b1);
        run("zero_p_nzero", 8'h00, 8'h80, 1'b1, 8'h00, lat_of(0, 0, 1), 1'b1);
        run("zero_m_3",     8'h00, 8'h44, 1'b0, 8'hC4, lat_of(0, 0, 1), 1'b1);
        run("exact_zero",   8'h44, 8'h44, 1'b0, 8'h00, lat_of(0, 0, 0), 1'b1);
        run("neg_result",   8'h40, 8'h44, 1'b0, 8'hB8, lat_of(0, 1, 0), 1'b1);
        run("neg_sum",      8'hC4, 8'h40, 1'b0, 8'hCA, lat_of(0, 0, 0), 1'b1);
        run("underflow",    8'h09, 8'h08, 1'b0, 8'h00, lat_of(0, 3, 0), 1'b1);
        run("far_align",    8'h70, 8'h08, 1'b1, 8'h70, lat_of(13, 0, 0), 1'b1);
        run("sticky_sub",   8'h38, 8'h08, 1'b0, 8'h38, lat_of(6, 1, 0), 1'b1);
        run("d6_add",       8'h68, 8'h38, 1'b1, 8'h68, lat_of(6, 0, 0), 1'b1);

        // start pulsed while busy is ignored
        @(negedge clk);
        a = 8'h44; b = 8'h40; addnot_sub = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        a = 8'h78; b = 8'h78; addnot_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_ready(2, lat);
        chk("busy_start_out", {24'd0, out}, 32'h4A);
        chk("busy_start_lat", lat, lat_of(0, 0, 0));
        repeat (3) @(posedge clk);
        #1;
        chk("busy_start_hold", {22'd0, out, ready, busy}, {22'd0, 8'h4A, 1'b1, 1'b0});

        // Reset while aligning a d=6 operation drops it
        @(negedge clk);
        a = 8'h68; b = 8'h38; addnot_sub = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_reset_busy", {31'd0, busy}, 32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_op_reset", {22'd0, out, ready, busy}, 32'h0);
        rst_n = 1'b1;
        run("post_reset",   8'h44, 8'h40, 1'b1, 8'h4A, lat_of(0, 0, 0), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
